uart_tx_bus: RTL and testbench

- Memory-mapped UART transmitter. Acts as a bus responder on the CPU request/ready bus, in a slot of the 0x5000_00x0 peripheral window.
- The CPU pushes bytes into an internal FIFO. The block serialises them on o_tx as 8N1, LSB first, with the line idle high.
- It is the transmit-side counterpart of the UART receive model used on the bench, which sits on the far end of o_tx.

---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/uart_tx_bus_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_bus.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_bus.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets (decoded from address bits [3:2]), the STATUS
// bit positions, and the state encodings of the bus and TX FSMs.
package uart_tx_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_ACTIVE    = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_bus_if.sv
// CPU request/ready bus between an initiator (master) and the UART
// transmitter (slave).
//   i_request : request, held by the initiator until it sees o_ready
//   i_rw      : 1 = write, 0 = read
//   i_address : window-relative byte address
//   i_wdata   : write data
//   o_rdata   : read data, valid while o_ready = 1
//   o_ready   : access complete
interface uart_tx_bus_if;
  logic        i_request;
  logic        i_rw;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;

  modport master (
    output i_request, i_rw, i_address, i_wdata,
    input  o_rdata, o_ready
  );

  modport slave (
    input  i_request, i_rw, i_address, i_wdata,
    output o_rdata, o_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous single-clock byte FIFO for the UART transmitter.
//   i_clock, i_reset : clock, synchronous active-high reset
//   push, wdata      : enqueue wdata (ignored while full)
//   pop              : dequeue (ignored while empty)
//   flush            : empty the FIFO; beats a same-cycle push or pop
//   rdata            : head entry, combinational from the read pointer
//   empty, full      : occupancy flags
//   count            : occupancy, 0..DEPTH
module uart_tx_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned COUNT_W = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  output logic               empty,
  output logic               full,
  output logic [COUNT_W-1:0] count
);

  localparam int unsigned PTR_W = COUNT_W - 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == COUNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge i_clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge i_clock) begin
    if (i_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + COUNT_W'(do_push) - COUNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_bus.sv
// Memory-mapped 8N1 UART transmitter, LSB first, line idle high.
//   i_clock, i_reset : clock, synchronous active-high reset
//   bus              : CPU request/ready bus (slave side)
//   o_tx             : serial output
//   o_busy           : FIFO non-empty or frame in progress (registered)
// Registers (address bits [3:2]): 0 DATA (write pushes a byte), 1 STATUS,
// 2 CONTROL (bit0 = flush), 3 reserved. Unlisted reads return 0.
module uart_tx_bus
  import uart_tx_pkg::*;
#(
  parameter int unsigned PRESCALE   = 868,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned COUNT_W    = 5
) (
  input  logic           i_clock,
  input  logic           i_reset,
  uart_tx_bus_if.slave   bus,
  output logic           o_tx,
  output logic           o_busy
);

  localparam int unsigned BAUD_W = $clog2(PRESCALE);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(PRESCALE - 1);

  bus_state_t          bus_state;
  tx_state_t           tx_state;
  logic [7:0]          shift;
  logic [2:0]          bit_idx;
  logic [BAUD_W-1:0]   baud_cnt;

  logic [7:0]          fifo_rdata;
  logic                fifo_empty;
  logic                fifo_full;
  logic [COUNT_W-1:0]  fifo_count;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;

  logic [1:0]          reg_sel;
  logic                accept;
  logic                tx_active;
  logic                baud_done;
  logic [31:0]         status_word;
  logic                unused_bits;

  assign reg_sel     = bus.i_address[3:2];
  assign unused_bits = ^{bus.i_address[31:4], bus.i_address[1:0], bus.i_wdata[31:8]};

  // A DATA write into a full FIFO is held off; the current full flag is
  // used even when a pop lands in the same cycle.
  assign accept     = (bus_state == BUS_IDLE) && bus.i_request &&
                      !(bus.i_rw && (reg_sel == ADDR_DATA) && fifo_full);
  assign fifo_push  = accept && bus.i_rw && (reg_sel == ADDR_DATA);
  assign fifo_flush = accept && bus.i_rw && (reg_sel == ADDR_CONTROL) && bus.i_wdata[0];
  // Gated by flush so the TX FSM never starts on a byte the flush discards.
  assign fifo_pop   = (tx_state == TX_IDLE) && !fifo_empty && !fifo_flush;

  assign tx_active  = (tx_state != TX_IDLE);
  assign baud_done  = (baud_cnt == '0);

  always_comb begin
    status_word                              = '0;
    status_word[ST_EMPTY]                    = fifo_empty;
    status_word[ST_FULL]                     = fifo_full;
    status_word[ST_ACTIVE]                   = tx_active;
    status_word[ST_COUNT_LSB +: COUNT_W]     = fifo_count;
  end

  uart_tx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .COUNT_W (COUNT_W)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wdata   (bus.i_wdata[7:0]),
    .rdata   (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Bus FSM: the side effect fires only on the IDLE->ACK transition, so a
  // request held high for many cycles acts once.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bus_state   <= BUS_IDLE;
      bus.o_ready <= 1'b0;
      bus.o_rdata <= '0;
    end else begin
      unique case (bus_state)
        BUS_IDLE: begin
          if (accept) begin
            bus_state   <= BUS_ACK;
            bus.o_ready <= 1'b1;
            bus.o_rdata <= (!bus.i_rw && (reg_sel == ADDR_STATUS)) ? status_word : '0;
          end
        end
        BUS_ACK: begin
          if (!bus.i_request) begin
            bus_state   <= BUS_IDLE;
            bus.o_ready <= 1'b0;
            bus.o_rdata <= '0;
          end
        end
      endcase
    end
  end

  // TX FSM: o_tx is loaded with the level of the state being entered, so the
  // registered output lines up with the state for the full bit time.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tx_state <= TX_IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      o_busy <= !fifo_empty || tx_active;
      unique case (tx_state)
        TX_IDLE: begin
          o_tx <= 1'b1;
          if (fifo_pop) begin
            shift    <= fifo_rdata;
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= '0;
            o_tx     <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (baud_done) begin
            baud_cnt <= BAUD_LOAD;
            o_tx     <= shift[0];
            tx_state <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
              o_tx     <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              o_tx    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            tx_state <= TX_IDLE;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_bus.sv
// Directed bench for uart_tx_bus. DUT A (PRESCALE=4) covers reset, single
// frames, back-pressure, flush and mid-frame reset, with a receive model on
// its serial line. DUT B (PRESCALE=64) keeps its TX path busy for the
// held-request case.
module tb_uart_tx_bus;
  import uart_tx_pkg::*;

  localparam int unsigned PA = 4;
  localparam int unsigned PB = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_bus_if ifa ();
  uart_tx_bus_if ifb ();
  logic a_tx, a_busy, b_tx, b_busy;

  uart_tx_bus #(.PRESCALE(PA), .FIFO_DEPTH(16), .COUNT_W(5)) dut_a (
    .i_clock (clk), .i_reset (rst), .bus (ifa), .o_tx (a_tx), .o_busy (a_busy)
  );
  uart_tx_bus #(.PRESCALE(PB), .FIFO_DEPTH(16), .COUNT_W(5)) dut_b (
    .i_clock (clk), .i_reset (rst), .bus (ifb), .o_tx (b_tx), .o_busy (b_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] rx_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Receive model on DUT A: mid-bit sampling, frames cut by reset discarded.
  initial begin : rx_model
    logic [7:0] b;
    bit aborted;
    int w;
    forever begin
      @(negedge clk);
      if (!rst && a_tx === 1'b0) begin
        aborted = 1'b0;
        b = '0;
        for (int n = 0; n < 9; n++) begin
          w = (n == 0) ? int'(PA + PA / 2) : int'(PA);
          for (int k = 0; k < w; k++) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          if (n < 8) b[n] = a_tx;
          else if (a_tx !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) rx_q.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_op(input bit b, input bit rw, input logic [1:0] sel,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
    bit rdy;
    if (b) begin
      ifb.i_request = 1'b1; ifb.i_rw = rw; ifb.i_address = {28'h5000000, sel, 2'b00}; ifb.i_wdata = wd;
    end else begin
      ifa.i_request = 1'b1; ifa.i_rw = rw; ifa.i_address = {28'h5000000, sel, 2'b00}; ifa.i_wdata = wd;
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      rdy = b ? (ifb.o_ready === 1'b1) : (ifa.o_ready === 1'b1);
    end while (!rdy && lat < 200);
    if (!rdy) lat = -1;
    rd = b ? ifb.o_rdata : ifa.o_rdata;
    if (b) ifb.i_request = 1'b0;
    else   ifa.i_request = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (a_busy !== 1'b0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(a_busy), 64'(0));
  endtask

  initial begin : main
    logic [31:0] rd;
    int lat;
    int hi;
    int nbad;
    int p;
    int lats [18];
    logic [39:0] txcap;
    logic busy40, busy41;
    logic saw_low;

    ifa.i_request = 1'b0; ifa.i_rw = 1'b0; ifa.i_address = '0; ifa.i_wdata = '0;
    ifb.i_request = 1'b0; ifb.i_rw = 1'b0; ifb.i_address = '0; ifb.i_wdata = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({ifa.o_ready, ifa.o_rdata, a_tx, a_busy}), 64'({1'b0, 32'h0, 1'b1, 1'b0}));
    rst = 1'b0;

    // Held request on B while its first frame (640 cycles) blocks the FIFO.
    bus_op(1'b1, 1'b1, ADDR_DATA, 32'h11, rd, lat);
    check("b_first_write_lat", 64'(lat), 64'(1));
    bus_op(1'b1, 1'b0, ADDR_STATUS, 32'h0, rd, lat);
    check("b_status_before", 64'(rd), 64'h0000_0005);
    ifb.i_request = 1'b1; ifb.i_rw = 1'b1; ifb.i_address = 32'h5000_0000; ifb.i_wdata = 32'h3C;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ifb.o_ready === 1'b1) hi++;
    end
    check("b_held_ready_cycles", 64'(hi), 64'(20));
    ifb.i_request = 1'b0;
    @(posedge clk); #1;
    bus_op(1'b1, 1'b0, ADDR_STATUS, 32'h0, rd, lat);
    check("b_status_after", 64'(rd), 64'h0000_0104);

    // Default state on A.
    bus_op(1'b0, 1'b0, ADDR_STATUS, 32'h0, rd, lat);
    check("a_status_lat", 64'(lat), 64'(1));
    check("a_status_idle", 64'(rd), 64'h0000_0001);
    check("a_idle_lines", 64'({a_tx, a_busy, ifa.o_ready, ifa.o_rdata}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
    bus_op(1'b0, 1'b0, ADDR_CONTROL, 32'h0, rd, lat);
    check("a_control_read", 64'(rd), 64'h0);
    bus_op(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, rd, lat);
    check("a_reserved_write_ack", 64'(lat), 64'(1));

    // Single byte 0x55: start, 1,0,1,0,1,0,1,0, stop; 4 cycles per bit.
    bus_op(1'b0, 1'b1, ADDR_DATA, 32'hFFFF_FF55, rd, lat);
    check("single_write_lat", 64'(lat), 64'(1));
    busy40 = 1'bx; busy41 = 1'bx; txcap = '0;
    for (int i = 0; i < 42; i++) begin
      if (i < 40) txcap[i] = a_tx;
      if (i == 40) busy40 = a_busy;
      if (i == 41) busy41 = a_busy;
      @(posedge clk); #1;
    end
    check("single_waveform", 64'(txcap), 64'h00_F0F0_F0F0_F0);
    check("single_busy_fall", 64'({busy40, busy41}), 64'(2'b10));
    check("single_rx_count", 64'(rx_q.size()), 64'(1));
    if (rx_q.size() > 0) check("single_rx_byte", 64'(rx_q.pop_front()), 64'h55);

    // Back-pressure: 18 back-to-back writes into a 16-deep FIFO.
    for (int j = 0; j < 18; j++) bus_op(1'b0, 1'b1, ADDR_DATA, 32'(j), rd, lats[j]);
    nbad = 0;
    for (int j = 0; j < 17; j++) if (lats[j] != 1) nbad++;
    check("bp_spacing_bad", 64'(nbad), 64'(0));
    check("bp_stall_lat", 64'(lats[17]), 64'(10));
    wait_idle("bp_drain", 2000);
    check("bp_rx_count", 64'(rx_q.size()), 64'(18));
    nbad = 0;
    for (int j = 0; j < 18; j++) begin
      if (rx_q.size() == 0 || rx_q.pop_front() !== 8'(j)) nbad++;
    end
    check("bp_rx_order_bad", 64'(nbad), 64'(0));

    // Flush during the first frame.
    bus_op(1'b0, 1'b1, ADDR_DATA, 32'hA5, rd, lat);
    bus_op(1'b0, 1'b1, ADDR_DATA, 32'h01, rd, lat);
    bus_op(1'b0, 1'b1, ADDR_DATA, 32'h02, rd, lat);
    bus_op(1'b0, 1'b1, ADDR_DATA, 32'h03, rd, lat);
    bus_op(1'b0, 1'b0, ADDR_STATUS, 32'h0, rd, lat);
    check("flush_status_before", 64'(rd), 64'h0000_0304);
    bus_op(1'b0, 1'b1, ADDR_CONTROL, 32'h1, rd, lat);
    wait_idle("flush_drain", 200);
    repeat (20) @(posedge clk);
    #1;
    check("flush_rx_count", 64'(rx_q.size()), 64'(1));
    if (rx_q.size() > 0) check("flush_rx_byte", 64'(rx_q.pop_front()), 64'hA5);
    bus_op(1'b0, 1'b0, ADDR_STATUS, 32'h0, rd, lat);
    check("flush_status_after", 64'(rd), 64'h0000_0001);

    // Reset during data bit 3 of 0xF0 with two bytes queued.
    bus_op(1'b0, 1'b1, ADDR_DATA, 32'hF0, rd, lat);
    p = cyc;
    bus_op(1'b0, 1'b1, ADDR_DATA, 32'h11, rd, lat);
    bus_op(1'b0, 1'b1, ADDR_DATA, 32'h22, rd, lat);
    while (cyc < p + 17 && cyc < p + 100) begin
      @(posedge clk); #1;
    end
    check("rst_bit3_level", 64'(a_tx), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_lines", 64'({a_tx, a_busy, ifa.o_ready}), 64'(3'b100));
    rst = 1'b0;
    bus_op(1'b0, 1'b0, ADDR_STATUS, 32'h0, rd, lat);
    check("rst_status_after", 64'(rd), 64'h0000_0001);
    saw_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (a_tx !== 1'b1) saw_low = 1'b1;
    end
    check("rst_no_frames", 64'({saw_low, 8'(rx_q.size())}), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
